// File: rtl/axis_bpsk_mod_if.sv
// Stream bundle around the BPSK modulator: data-word input channel plus symbol output channel.
// The master modport is the modulator (symbol source); the slave modport is its surroundings.
interface axis_bpsk_mod_if #(
   parameter int DATA_WIDTH = 8,
   parameter int SYM_WIDTH  = 23
);
   logic [DATA_WIDTH-1:0]       s_axis_tdata;
   logic                        s_axis_tvalid;
   logic                        s_axis_tlast;
   logic                        s_axis_tready;
   logic signed [SYM_WIDTH-1:0] m_axis_tdata_re;
   logic signed [SYM_WIDTH-1:0] m_axis_tdata_im;
   logic                        m_axis_tvalid;
   logic                        m_axis_tlast;
   logic                        m_axis_tready;

   modport master (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tdata_re, m_axis_tdata_im, m_axis_tvalid, m_axis_tlast
   );

   modport slave (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tdata_re, m_axis_tdata_im, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/axis_bpsk_mod.sv
// BPSK modulator: serializes stream words LSB first, one real +/-AMP symbol per output beat.
// Bit 0 maps to +AMP and bit 1 to -AMP, so a receiver slicer decodes re < 0 as 1.
module axis_bpsk_mod #(
   parameter int DATA_WIDTH = 8,
   parameter int SYM_WIDTH  = 23,
   parameter int AMP        = 2097152
) (
   input  logic            aclk,
   input  logic            aresetn,
   axis_bpsk_mod_if.master axis
);
   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] PENULT_BIT = CNT_W'(DATA_WIDTH - 2);
   localparam logic signed [SYM_WIDTH-1:0] SYM_POS = SYM_WIDTH'(AMP);
   localparam logic signed [SYM_WIDTH-1:0] SYM_NEG = SYM_WIDTH'(-AMP);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                      state_reg, state_next;
   // Holds only the not-yet-sent bits; bit 0 of a word goes straight to the output register.
   logic [DATA_WIDTH-2:0]       shreg_reg;
   logic [CNT_W-1:0]            bitcnt_reg;
   logic                        last_q_reg;
   logic                        ready_en_reg;
   logic signed [SYM_WIDTH-1:0] re_reg;
   logic                        valid_reg;
   logic                        tlast_reg;

   logic s_ready;
   logic accept;
   logic beat;
   logic word_done;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (accept) state_next = SHIFT;
         SHIFT: if (beat && word_done && !axis.s_axis_tvalid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // s_ready only looks at m_axis_tready on the final bit, so back-to-back words flow without a bubble.
   always_comb begin
      beat      = valid_reg & axis.m_axis_tready;
      word_done = (bitcnt_reg == LAST_BIT);
      s_ready   = 1'b0;
      case (state_reg)
         IDLE:    s_ready = ready_en_reg;
         SHIFT:   s_ready = word_done & axis.m_axis_tready;
         default: s_ready = 1'b0;
      endcase
      accept = axis.s_axis_tvalid & s_ready;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         shreg_reg    <= '0;
         bitcnt_reg   <= '0;
         last_q_reg   <= 1'b0;
         ready_en_reg <= 1'b0;
         re_reg       <= '0;
         valid_reg    <= 1'b0;
         tlast_reg    <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;
         if (accept) begin
            shreg_reg  <= axis.s_axis_tdata[DATA_WIDTH-1:1];
            last_q_reg <= axis.s_axis_tlast;
            bitcnt_reg <= '0;
            re_reg     <= axis.s_axis_tdata[0] ? SYM_NEG : SYM_POS;
            valid_reg  <= 1'b1;
            tlast_reg  <= 1'b0;
         end else if (beat) begin
            if (word_done) begin
               valid_reg <= 1'b0;
               tlast_reg <= 1'b0;
            end else begin
               shreg_reg  <= shreg_reg >> 1;
               bitcnt_reg <= bitcnt_reg + 1'b1;
               re_reg     <= shreg_reg[0] ? SYM_NEG : SYM_POS;
               tlast_reg  <= last_q_reg & (bitcnt_reg == PENULT_BIT);
            end
         end
      end
   end

   assign axis.s_axis_tready   = s_ready;
   assign axis.m_axis_tdata_re = re_reg;
   assign axis.m_axis_tdata_im = '0;
   assign axis.m_axis_tvalid   = valid_reg;
   assign axis.m_axis_tlast    = tlast_reg;
endmodule
